// File: rtl/ysyx_23060201_lsu_if.sv
// LSU bundle: EXU request, WBU response and data-memory port; master = LSU side.
// out_misalign exists only when YSYX_23060201_LSU_MISALIGN_EN is defined.
interface ysyx_23060201_lsu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_is_load;
   logic                  in_is_store;
   logic [2:0]            in_funct3;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_wdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_rdata;
`ifdef YSYX_23060201_LSU_MISALIGN_EN
   logic                  out_misalign;
`endif
   logic                  mem_ren;
   logic [ADDR_WIDTH-1:0] mem_raddr;
   logic [7:0]            mem_rmask;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_wen;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [7:0]            mem_wmask;
   logic [DATA_WIDTH-1:0] mem_wdata;

   modport master (
      input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
      input  out_ready, mem_rdata,
`ifdef YSYX_23060201_LSU_MISALIGN_EN
      output out_misalign,
`endif
      output in_ready, out_valid, out_rdata,
      output mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata
   );

   modport slave (
      output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
      output out_ready, mem_rdata,
`ifdef YSYX_23060201_LSU_MISALIGN_EN
      input  out_misalign,
`endif
      input  in_ready, out_valid, out_rdata,
      input  mem_ren, mem_raddr, mem_rmask, mem_wen, mem_waddr, mem_wmask, mem_wdata
   );
endinterface

// File: rtl/ysyx_23060201_lsu.sv
// Single-outstanding load/store unit: IDLE->ISSUE->(WAIT)->RESP, load 3 / store 2 cycles to out_valid.
// Holds the result in RESP until out_ready; YSYX_23060201_LSU_MISALIGN_EN adds misalignment trapping.
module ysyx_23060201_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic                 clk,
   input logic                 rst,
   ysyx_23060201_lsu_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  is_load_q;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  accept;
   logic                  in_misalign;
   logic [1:0]            off;
   logic [3:0]            lane_mask;
   logic [DATA_WIDTH-1:0] rshift;

   assign accept = (state_q == S_IDLE) && bus.in_valid && (bus.in_is_load || bus.in_is_store);

`ifdef YSYX_23060201_LSU_MISALIGN_EN
   logic misalign_q;

   always_comb begin
      in_misalign = 1'b0;
      case (bus.in_funct3)
         3'b001, 3'b101: in_misalign = bus.in_addr[0];
         3'b010:         in_misalign = |bus.in_addr[1:0];
         default:        in_misalign = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (accept) begin
         misalign_q <= in_misalign;
      end
   end

   assign bus.out_misalign = (state_q == S_RESP) && misalign_q;
`else
   assign in_misalign = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = in_misalign ? S_RESP : S_ISSUE;
         S_ISSUE: state_d = is_load_q ? S_WAIT : S_RESP;
         S_WAIT:  state_d = S_RESP;
         S_RESP:  if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Lane offset follows the natural alignment: sub-alignment address bits are ignored.
   always_comb begin
      off       = 2'b00;
      lane_mask = 4'b0000;
      case (funct3_q)
         3'b000, 3'b100: begin
            off       = addr_q[1:0];
            lane_mask = 4'b0001 << addr_q[1:0];
         end
         3'b001, 3'b101: begin
            off       = {addr_q[1], 1'b0};
            lane_mask = 4'b0011 << {addr_q[1], 1'b0};
         end
         3'b010:  lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   end

   assign rshift = bus.mem_rdata >> {off, 3'b000};

   always_comb begin
      rdata_d = '0;
      case (funct3_q)
         3'b000:  rdata_d = {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
         3'b100:  rdata_d = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
         3'b001:  rdata_d = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
         3'b101:  rdata_d = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
         3'b010:  rdata_d = rshift;
         default: rdata_d = '0;
      endcase
   end

   // Result is cleared on accept so stores and trapped requests return 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         funct3_q  <= '0;
         wdata_q   <= '0;
         is_load_q <= 1'b0;
         rdata_q   <= '0;
      end else if (accept) begin
         addr_q    <= bus.in_addr;
         funct3_q  <= bus.in_funct3;
         wdata_q   <= bus.in_wdata;
         is_load_q <= bus.in_is_load;
         rdata_q   <= '0;
      end else if (state_q == S_WAIT) begin
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == S_IDLE);
      bus.out_valid = (state_q == S_RESP);
      bus.out_rdata = rdata_q;
      bus.mem_ren   = 1'b0;
      bus.mem_raddr = '0;
      bus.mem_rmask = '0;
      bus.mem_wen   = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_wmask = '0;
      bus.mem_wdata = '0;
      if (state_q == S_ISSUE) begin
         if (is_load_q) begin
            bus.mem_ren   = 1'b1;
            bus.mem_raddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            bus.mem_rmask = {4'b0000, lane_mask};
         end else begin
            bus.mem_wen   = 1'b1;
            bus.mem_waddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            bus.mem_wmask = {4'b0000, lane_mask};
            bus.mem_wdata = wdata_q << {off, 3'b000};
         end
      end
   end

endmodule
